// File: rtl/msg_word_sender.sv
// msg_word_sender: Avalon-ST packet source fed by an internal word FIFO.
// Ports: clk, rst_n, wr_en/wr_data/full (FIFO push side),
//   cmd_valid/cmd_len/cmd_ready (packet command), busy,
//   msg_out (avalon_st_if.master), cntr (words sent in packet).
// Optional: define MSG_WORD_SENDER_PKT_CNT_EN to add pkt_cnt[15:0].

package aes_top_pack;
    localparam int WORD_COUNTER_SIZE = 16;
endpackage

interface avalon_st_if #(
    parameter int DATA_W = 128
);
    logic              valid;
    logic              ready;
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;

    modport master (
        output valid, data, sop, eop,
        input  ready
    );
    modport slave (
        input  valid, data, sop, eop,
        output ready
    );
endinterface

module msg_word_sender
    import aes_top_pack::*;
#(
    parameter int DATA_W     = 128,
    parameter int LEN_W      = WORD_COUNTER_SIZE,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    input  logic              cmd_valid,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              cmd_ready,
    output logic              busy,
    avalon_st_if.master       msg_out,
`ifdef MSG_WORD_SENDER_PKT_CNT_EN
    output logic [15:0]       pkt_cnt,
`endif
    output logic [LEN_W-1:0]  cntr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        LAST
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic [AW:0]       count;
    logic              empty;
    logic              push;
    logic              load;
    logic              hs;

    logic              valid_q;
    logic              sop_q;
    logic              eop_q;
    logic [DATA_W-1:0] data_q;
    logic [LEN_W-1:0]  rem_q;
    logic              first_q;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign count = wptr - rptr;
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign push  = wr_en && !full;
    assign hs    = valid_q && msg_out.ready;
    assign busy  = (state_q != IDLE);

    assign msg_out.valid = valid_q;
    assign msg_out.sop   = sop_q;
    assign msg_out.eop   = eop_q;
    assign msg_out.data  = data_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (load) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        load      = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && cmd_len != '0) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                // Refill only when the output slot is free or draining.
                load = (!valid_q || msg_out.ready) && !empty;
                if (load && rem_q == LEN_W'(1)) begin
                    state_d = LAST;
                end
            end
            LAST: begin
                if (hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
            rem_q   <= '0;
            first_q <= 1'b0;
            cntr    <= '0;
        end else begin
            state_q <= state_d;
            if (cmd_ready && cmd_valid && cmd_len != '0) begin
                rem_q   <= cmd_len;
                first_q <= 1'b1;
            end
            if (load) begin
                valid_q <= 1'b1;
                data_q  <= mem[rptr[AW-1:0]];
                sop_q   <= first_q;
                eop_q   <= (rem_q == LEN_W'(1));
                first_q <= 1'b0;
                rem_q   <= rem_q - 1'b1;
            end else if (hs) begin
                valid_q <= 1'b0;
            end
            if (hs) begin
                cntr <= sop_q ? LEN_W'(1) : cntr + 1'b1;
            end
        end
    end

`ifdef MSG_WORD_SENDER_PKT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else if (hs && eop_q) begin
            pkt_cnt <= pkt_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_msg_word_sender.sv
// tb_msg_word_sender: directed bench for msg_word_sender.
// Drives inputs 1ns after posedge, samples outputs on negedge.

module tb_msg_word_sender;

    logic         clk;
    logic         rst_n;
    logic         wr_en;
    logic [127:0] wr_data;
    logic         full;
    logic         cmd_valid;
    logic [15:0]  cmd_len;
    logic         cmd_ready;
    logic         busy;
    logic [15:0]  cntr;
`ifdef MSG_WORD_SENDER_PKT_CNT_EN
    logic [15:0]  pkt_cnt;
`endif

    int checks;
    int errors;
    int cyc;

    logic [127:0] q_data [$];
    bit           q_sop  [$];
    bit           q_eop  [$];
    int           q_cyc  [$];

    avalon_st_if #(.DATA_W(128)) m ();

    msg_word_sender dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .cmd_valid (cmd_valid),
        .cmd_len   (cmd_len),
        .cmd_ready (cmd_ready),
        .busy      (busy),
        .msg_out   (m),
`ifdef MSG_WORD_SENDER_PKT_CNT_EN
        .pkt_cnt   (pkt_cnt),
`endif
        .cntr      (cntr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Handshake log: valid && ready at negedge completes on the next edge.
    always @(negedge clk) begin
        if (rst_n && m.valid && m.ready) begin
            q_data.push_back(m.data);
            q_sop.push_back(m.sop);
            q_eop.push_back(m.eop);
            q_cyc.push_back(cyc);
        end
    end

    task automatic clear_log();
        q_data.delete();
        q_sop.delete();
        q_eop.delete();
        q_cyc.delete();
    endtask

    task automatic push_word(input logic [127:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic send_cmd(input logic [15:0] len);
        cmd_valid = 1'b1;
        cmd_len   = len;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({m.valid, m.sop, m.eop, full, busy, cmd_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_flags got %b want 000001",
                     {m.valid, m.sop, m.eop, full, busy, cmd_ready});
        end
        checks++;
        if (m.data !== 128'h0 || cntr !== 16'h0) begin
            errors++;
            $display("FAIL reset_data got %h/%h want 0/0", m.data, cntr);
        end
`ifdef MSG_WORD_SENDER_PKT_CNT_EN
        checks++;
        if (pkt_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_pkt_cnt got %h want 0", pkt_cnt);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [127:0] a [4];
        clear_log();
        for (int k = 0; k < 4; k++) a[k] = 128'hA0 + 128'(k);
        for (int k = 0; k < 4; k++) push_word(a[k]);
        send_cmd(16'd4);
        @(negedge clk);
        checks++;
        if (m.valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_lat got v=%b b=%b want v=0 b=1",
                     m.valid, busy);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({m.valid, m.sop, m.eop} !== {1'b1, k == 0, k == 3} ||
                m.data !== a[k] || cntr !== 16'(k)) begin
                errors++;
                $display("FAIL basic_word%0d got %b %h c=%0d want %b %h c=%0d",
                         k, {m.valid, m.sop, m.eop}, m.data, cntr,
                         {1'b1, k == 0, k == 3}, a[k], k);
            end
        end
        @(negedge clk);
        checks++;
        if (m.valid !== 1'b0 || busy !== 1'b0 || cntr !== 16'd4 ||
            cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_end got v=%b b=%b c=%0d r=%b want 0 0 4 1",
                     m.valid, busy, cntr, cmd_ready);
        end
    endtask

    task automatic test_backpressure();
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit           pv;
        logic [127:0] pd;
        bit           ps;
        bit           pe;
        clear_log();
        pv = 1'b0;
        for (int k = 0; k < 4; k++) push_word(128'hB0 + 128'(k));
        send_cmd(16'd4);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            m.ready = pat[c % 4];
            @(negedge clk);
            if (pv) begin
                checks++;
                if (m.valid !== 1'b1 || m.data !== pd ||
                    m.sop !== ps || m.eop !== pe) begin
                    errors++;
                    $display("FAIL bp_hold got %b %h %b%b want 1 %h %b%b",
                             m.valid, m.data, m.sop, m.eop, pd, ps, pe);
                end
            end
            pv = m.valid && !m.ready;
            pd = m.data;
            ps = m.sop;
            pe = m.eop;
            if (!busy) break;
        end
        m.ready = 1'b1;
        checks++;
        if (busy !== 1'b0 || q_data.size() != 4) begin
            errors++;
            $display("FAIL bp_done got busy=%b n=%0d want 0 4",
                     busy, q_data.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (q_data[k] !== 128'hB0 + 128'(k) ||
                    q_sop[k] !== (k == 0) || q_eop[k] !== (k == 3)) begin
                    errors++;
                    $display("FAIL bp_word%0d got %h %b%b", k,
                             q_data[k], q_sop[k], q_eop[k]);
                end
            end
        end
        checks++;
        if (cntr !== 16'd4) begin
            errors++;
            $display("FAIL bp_cntr got %0d want 4", cntr);
        end
    endtask

    task automatic test_bubble();
        clear_log();
        send_cmd(16'd3);
        for (int k = 0; k < 3; k++) begin
            push_word(128'hC0 + 128'(k));
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
        end
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || q_data.size() != 3) begin
            errors++;
            $display("FAIL bubble_done got busy=%b n=%0d want 0 3",
                     busy, q_data.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (q_data[k] !== 128'hC0 + 128'(k) ||
                    q_sop[k] !== (k == 0) || q_eop[k] !== (k == 2)) begin
                    errors++;
                    $display("FAIL bubble_word%0d got %h %b%b", k,
                             q_data[k], q_sop[k], q_eop[k]);
                end
            end
            checks++;
            if (q_cyc[1] - q_cyc[0] != 3 || q_cyc[2] - q_cyc[1] != 3) begin
                errors++;
                $display("FAIL bubble_gap got %0d,%0d want 3,3",
                         q_cyc[1] - q_cyc[0], q_cyc[2] - q_cyc[1]);
            end
        end
        checks++;
        if (cntr !== 16'd3) begin
            errors++;
            $display("FAIL bubble_cntr got %0d want 3", cntr);
        end
    endtask

    task automatic test_full();
        clear_log();
        for (int k = 0; k < 18; k++) begin
            push_word(128'hD00 + 128'(k));
            if (k == 14) begin
                checks++;
                if (full !== 1'b0) begin
                    errors++;
                    $display("FAIL full_15 got %b want 0", full);
                end
            end
            if (k == 15 || k == 17) begin
                checks++;
                if (full !== 1'b1) begin
                    errors++;
                    $display("FAIL full_%0d got %b want 1", k + 1, full);
                end
            end
        end
        send_cmd(16'd16);
        // Push during the first pop while still full: must be dropped.
        push_word(128'hDEAD);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checks++;
        if (busy !== 1'b0 || q_data.size() != 16) begin
            errors++;
            $display("FAIL full_done got busy=%b n=%0d want 0 16",
                     busy, q_data.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                checks++;
                if (q_data[k] !== 128'hD00 + 128'(k) ||
                    q_sop[k] !== (k == 0) || q_eop[k] !== (k == 15)) begin
                    errors++;
                    $display("FAIL full_word%0d got %h %b%b", k,
                             q_data[k], q_sop[k], q_eop[k]);
                end
            end
        end
        checks++;
        if (cntr !== 16'd16 || full !== 1'b0) begin
            errors++;
            $display("FAIL full_end got c=%0d f=%b want 16 0", cntr, full);
        end
        clear_log();
        push_word(128'hF0);
        push_word(128'hF1);
        send_cmd(16'd2);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checks++;
        if (q_data.size() != 2) begin
            errors++;
            $display("FAIL full_after got n=%0d want 2", q_data.size());
        end else begin
            checks++;
            if (q_data[0] !== 128'hF0 || q_data[1] !== 128'hF1) begin
                errors++;
                $display("FAIL full_excess got %h %h want f0 f1",
                         q_data[0], q_data[1]);
            end
        end
    endtask

    task automatic test_zero_one();
        do_reset();
        clear_log();
        send_cmd(16'd0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || m.valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_len got b=%b v=%b r=%b want 0 0 1",
                     busy, m.valid, cmd_ready);
        end
`ifdef MSG_WORD_SENDER_PKT_CNT_EN
        checks++;
        if (pkt_cnt !== 16'd0) begin
            errors++;
            $display("FAIL zero_pkt_cnt got %0d want 0", pkt_cnt);
        end
`endif
        push_word(128'hE0);
        send_cmd(16'd1);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checks++;
        if (q_data.size() != 1) begin
            errors++;
            $display("FAIL one_count got %0d want 1", q_data.size());
        end else begin
            checks++;
            if (q_data[0] !== 128'hE0 || q_sop[0] !== 1'b1 ||
                q_eop[0] !== 1'b1) begin
                errors++;
                $display("FAIL one_word got %h %b%b want e0 11",
                         q_data[0], q_sop[0], q_eop[0]);
            end
        end
        checks++;
        if (cntr !== 16'd1) begin
            errors++;
            $display("FAIL one_cntr got %0d want 1", cntr);
        end
`ifdef MSG_WORD_SENDER_PKT_CNT_EN
        checks++;
        if (pkt_cnt !== 16'd1) begin
            errors++;
            $display("FAIL one_pkt_cnt got %0d want 1", pkt_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid();
        bit found;
        bit eop_seen;
        clear_log();
        found = 1'b0;
        for (int k = 0; k < 4; k++) push_word(128'h60 + 128'(k));
        send_cmd(16'd4);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (m.valid && m.data === 128'h61) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rmid_word2 got none want 61");
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m.valid, m.sop, m.eop, busy, cmd_ready} !== 5'b00001 ||
            m.data !== 128'h0 || cntr !== 16'h0 || full !== 1'b0) begin
            errors++;
            $display("FAIL rmid_reset got %b %h c=%0d f=%b",
                     {m.valid, m.sop, m.eop, busy, cmd_ready},
                     m.data, cntr, full);
        end
        eop_seen = 1'b0;
        foreach (q_eop[i]) eop_seen |= q_eop[i];
        checks++;
        if (eop_seen) begin
            errors++;
            $display("FAIL rmid_eop got eop=1 want 0");
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
        push_word(128'h70);
        push_word(128'h71);
        send_cmd(16'd2);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checks++;
        if (q_data.size() != 2) begin
            errors++;
            $display("FAIL rmid_count got %0d want 2", q_data.size());
        end else begin
            checks++;
            if (q_data[0] !== 128'h70 || q_data[1] !== 128'h71 ||
                {q_sop[0], q_eop[0], q_sop[1], q_eop[1]} !== 4'b1001) begin
                errors++;
                $display("FAIL rmid_words got %h %h %b%b%b%b",
                         q_data[0], q_data[1],
                         q_sop[0], q_eop[0], q_sop[1], q_eop[1]);
            end
        end
        checks++;
        if (cntr !== 16'd2) begin
            errors++;
            $display("FAIL rmid_cntr got %0d want 2", cntr);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        m.ready   = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_bubble();
        test_full();
        test_zero_one();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/msg_word_sender.md
Name: msg_word_sender

Overview:
- Avalon-ST source that turns buffered words into framed packets.
- A producer pushes words into an internal FIFO, then issues a length command.
- The block emits that many words on an avalon_st_if master port, with sop on the first word and eop on the last, and honours ready backpressure.
- It drives the packet-word counting receivers on the message path.
- Its cntr output follows receive-side word-counter semantics, so transmit and receive counts compare directly.

Parameters:
- DATA_W, default 128: word width; must equal the data field width of the avalon_st_if instance.
- LEN_W, default WORD_COUNTER_SIZE (aes_top_pack): width of the packet length field and of cntr.
- FIFO_DEPTH, default 16: word FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  push wr_data into the FIFO.
- wr_data  in  DATA_W  word to push.
- full  out  1  FIFO full; a push while high is dropped.
- cmd_valid  in  1  packet command valid.
- cmd_len  in  LEN_W  packet length in words.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- busy  out  1  high when state is not IDLE.
- msg_out  avalon_st_if.master  -  drives valid, data, sop, eop; samples ready.
- cntr  out  LEN_W  words handshaken in the current packet.

Behaviour:
- Reset values: msg_out.valid, sop, eop = 0; msg_out.data = 0; cntr = 0; FIFO empty; full = 0; state = IDLE; cmd_ready = 1; busy = 0.
- Reset asserted mid-packet aborts the packet at once. No eop is emitted. After release the block is in IDLE with the FIFO empty.
- FIFO behaviour:
  - Push when not full stores the word.
  - Push when full is ignored.
  - full is combinational from the current occupancy.
  - A simultaneous push and pop while full still drops the push.
- FSM, three states: IDLE, SEND, LAST.
  - IDLE: cmd_ready = 1.
    - Command with cmd_len = 0: consumed, no output, stay in IDLE.
    - Command with cmd_len ≠ 0: latch rem = cmd_len and first = 1, go to SEND.
  - SEND, output-register load rule:
    - Load condition: (msg_out.valid == 0 or msg_out.ready == 1) and FIFO not empty.
    - On load: pop the FIFO, register data, set sop = first and eop = (rem == 1), clear first, decrement rem.
    - If the loaded word had rem == 1, go to LAST.
    - If the register drains and the FIFO is empty, drop valid (bubble). The packet resumes when data arrives; no filler words are ever sent.
  - LAST: hold the eop word until valid and ready are both high, then clear valid and go to IDLE.
  - cmd_ready = 0 in SEND and LAST.
- Avalon-ST output rules:
  - Once asserted, valid, data, sop and eop stay stable until ready is sampled high.
  - Throughput is 1 word/cycle while ready = 1 and the FIFO is non-empty.
- Latency: command accepted at edge T → first word valid in the cycle after edge T+1 (2 cycles), provided the FIFO is non-empty.
- Back-to-back packets: the next command is accepted in the cycle after the eop handshake.
- cntr, evaluated on each output handshake (valid and ready):
  - sop word: cntr ← 1.
  - Any other word: cntr ← cntr + 1, wrapping modulo 2^LEN_W.
  - cntr holds between packets.
- A single-word packet (cmd_len = 1) carries sop = eop = 1 on one word.

Optional Feature:
- Macro MSG_WORD_SENDER_PKT_CNT_EN.
- When defined:
  - Adds output pkt_cnt [15:0], reset 0.
  - pkt_cnt increments on each eop handshake and wraps at 2^16.
  - pkt_cnt does not change for zero-length commands.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Push 4 words A0..A3, command cmd_len = 4, ready = 1 → 4 consecutive valid cycles starting 2 cycles after command acceptance: sop on A0, eop on A3; cntr steps 1, 2, 3, 4; busy drops the cycle after the eop handshake.
- Same 4-word packet with ready toggling 1, 0, 0, 1, … → no word lost or duplicated; data/sop/eop stable while ready = 0; cntr ends at 4.
- Command cmd_len = 3 with the FIFO empty, then push 1 word every 3 cycles → valid bubbles between words, eop on the 3rd word, no extra output.
- Push FIFO_DEPTH + 2 words with no command pending → full = 1 after 16 pushes; after cmd_len = 16 exactly the first 16 words are sent, and the 2 excess words never appear.
- Commands cmd_len = 0 then cmd_len = 1 → no output for the first; one word with sop = eop = 1 for the second; with MSG_WORD_SENDER_PKT_CNT_EN defined, pkt_cnt = 1.
- Assert rst_n = 0 while a 4-word packet is at word 2 → outputs reach their reset values immediately; after release, a fresh cmd_len = 2 with 2 pushes yields sop/eop correctly and cntr = 2.
